// File: rtl/jpeg_dct_seq_if.sv
// Control bundle between the JPEG DCT sequencer and the datapath/DMA around it.
// The sequencer uses the master modport; the DMA side and datapath use slave.
interface jpeg_dct_seq_if;
  logic        start_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic [8:0]  rd_addr_o;
  logic        row_valid_o;
  logic        dct_en_o;
  logic        mux1_o;
  logic        t_wr_o;
  logic        t_rd_o;
  logic [1:0]  mux2_sel_o;
  logic [5:0]  rec_idx_o;
  logic        out_we_o;
  logic [4:0]  out_addr_o;
  logic [15:0] blocks_o;

  modport master (
    input  start_i, abort_i,
    output busy_o, done_o, rd_addr_o, row_valid_o, dct_en_o, mux1_o,
           t_wr_o, t_rd_o, mux2_sel_o, rec_idx_o, out_we_o, out_addr_o,
           blocks_o
  );

  modport slave (
    output start_i, abort_i,
    input  busy_o, done_o, rd_addr_o, row_valid_o, dct_en_o, mux1_o,
           t_wr_o, t_rd_o, mux2_sel_o, rec_idx_o, out_we_o, out_addr_o,
           blocks_o
  );
endinterface

// File: rtl/jpeg_dct_seq.sv
// 8x8 JPEG DCT block sequencer: row pass from input memory, transpose,
// column pass, quantiser pair writes to output memory. All outputs registered.
module jpeg_dct_seq #(
  parameter int unsigned DCT_LAT = 2,
  parameter logic [8:0]  IN_BASE = 9'h000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  jpeg_dct_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROWDRAIN,
    COL,
    COLDRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  word_q, word_d;
  logic [2:0]  rc_q, rc_d;
  logic [1:0]  pair_q, pair_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rv_q, rv_d;
  logic        trd_q, trd_d;
  logic        m1_q, m1_d;
  logic        we_q, we_d;
  logic [8:0]  rd_addr_q, rd_addr_d;
  logic [1:0]  m2_q, m2_d;
  logic [5:0]  rec_q, rec_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] blocks_q;

  // Delay lines modelling the DCT latency for row results and column results.
  logic [DCT_LAT-1:0] rv_pipe_q;
  logic [DCT_LAT-1:0] trd_pipe_q;

  logic kill;
  logic last_wr;
  logic kick;

  assign kill    = bus.abort_i && (state_q != IDLE);
  assign last_wr = we_q && (addr_q == 5'd31);
  assign kick    = trd_pipe_q[DCT_LAT-1];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      word_q  <= '0;
      rc_q    <= '0;
      pair_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rc_q    <= rc_d;
      pair_q  <= pair_d;
    end
  end

  // Next-state logic; the row/column counter counts transpose writes during
  // the row pass and wraps to 0 exactly on the 8th, ready for the column pass.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    rc_d    = rc_q;
    pair_d  = pair_q;
    if (kill) begin
      state_d = IDLE;
      word_d  = '0;
      rc_d    = '0;
      pair_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_i && !bus.abort_i) begin
            state_d = LOAD;
            word_d  = '0;
            rc_d    = '0;
            pair_d  = '0;
          end
        end
        LOAD: begin
          word_d = word_q + 4'd1;
          if (bus.t_wr_o) rc_d = rc_q + 3'd1;
          if (word_q == 4'd15) state_d = ROWDRAIN;
        end
        ROWDRAIN: begin
          if (bus.t_wr_o) begin
            rc_d = rc_q + 3'd1;
            if (rc_q == 3'd7) begin
              state_d = COL;
              pair_d  = '0;
            end
          end
        end
        COL: begin
          pair_d = pair_q + 2'd1;
          if (pair_q == 2'd3) begin
            rc_d = rc_q + 3'd1;
            if (rc_q == 3'd7) state_d = COLDRAIN;
          end
        end
        COLDRAIN: begin
          if (last_wr) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: next values of every registered output.
  // Column windows abut, so a write continues until the pair wraps and the
  // next column's delayed t_rd restarts it on the following cycle.
  always_comb begin
    busy_d    = (state_d != IDLE);
    m1_d      = (state_d == COL) || (state_d == COLDRAIN);
    rd_addr_d = (state_d == LOAD) ? IN_BASE + {5'd0, word_d} : IN_BASE;
    rv_d      = !kill && (state_q == LOAD) && word_q[0];
    trd_d     = (state_d == COL) && (pair_d == 2'd0);
    done_d    = !kill && (state_q == COLDRAIN) && last_wr;
    we_d      = !kill && (kick || (we_q && (addr_q[1:0] != 2'd3)));
    addr_d    = (we_d && we_q) ? addr_q + 5'd1 : '0;
    m2_d      = addr_d[1:0];
    rec_d     = {addr_d, 1'b0};
  end

  // Output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rv_q       <= 1'b0;
      trd_q      <= 1'b0;
      m1_q       <= 1'b0;
      we_q       <= 1'b0;
      rd_addr_q  <= IN_BASE;
      m2_q       <= '0;
      rec_q      <= '0;
      addr_q     <= '0;
      blocks_q   <= '0;
      rv_pipe_q  <= '0;
      trd_pipe_q <= '0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      rv_q       <= rv_d;
      trd_q      <= trd_d;
      m1_q       <= m1_d;
      we_q       <= we_d;
      rd_addr_q  <= rd_addr_d;
      m2_q       <= m2_d;
      rec_q      <= rec_d;
      addr_q     <= addr_d;
      blocks_q   <= blocks_q + {15'd0, done_d};
      rv_pipe_q  <= kill ? '0 : ((rv_pipe_q << 1) | DCT_LAT'(rv_q));
      trd_pipe_q <= kill ? '0 : ((trd_pipe_q << 1) | DCT_LAT'(trd_q));
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.dct_en_o    = busy_q;
  assign bus.done_o      = done_q;
  assign bus.rd_addr_o   = rd_addr_q;
  assign bus.row_valid_o = rv_q;
  assign bus.mux1_o      = m1_q;
  assign bus.t_wr_o      = rv_pipe_q[DCT_LAT-1];
  assign bus.t_rd_o      = trd_q;
  assign bus.mux2_sel_o  = m2_q;
  assign bus.rec_idx_o   = rec_q;
  assign bus.out_we_o    = we_q;
  assign bus.out_addr_o  = addr_q;
  assign bus.blocks_o    = blocks_q;

endmodule
